// File: rtl/spi_byte_transceiver_if.sv
`default_nettype none
// ============================================================================
// Module      : spi_byte_transceiver_if
// Description : Bundles the request/status and SPI bus signals of the
//               single-byte SPI master engine.
//               master modport : the engine itself (drives the SPI pins and
//                                the status outputs).
//               slave modport  : the client/slave side (issues requests,
//                                supplies miso, observes status).
// Signals     : send_request, din[7:0], cs_at_end, miso   (into the engine)
//               mosi, sclk, cs, dout[7:0], data_valid,
//               processing, bit_counter[3:0]             (out of the engine)
// Revision    : 1.0 - initial release
// ============================================================================
interface spi_byte_transceiver_if;
  logic       send_request;
  logic [7:0] din;
  logic       cs_at_end;
  logic       miso;
  logic       mosi;
  logic       sclk;
  logic       cs;
  logic [7:0] dout;
  logic       data_valid;
  logic       processing;
  logic [3:0] bit_counter;

  modport master (
    input  send_request, din, cs_at_end, miso,
    output mosi, sclk, cs, dout, data_valid, processing, bit_counter
  );

  modport slave (
    output send_request, din, cs_at_end, miso,
    input  mosi, sclk, cs, dout, data_valid, processing, bit_counter
  );
endinterface
`default_nettype wire

// File: rtl/spi_byte_transceiver.sv
`default_nettype none
// ============================================================================
// Module      : spi_byte_transceiver
// Description : Single-byte full-duplex SPI master, mode 0 (CPOL=0, CPHA=0),
//               MSB first. Shifts din out on mosi while shifting miso into
//               dout, entirely in the clk domain.
// Parameters  : HALF_PERIOD - clk cycles per sclk phase (1..255)
// Ports       : clk   - system clock, rising edge
//               reset - synchronous active-high reset
//               bus   - spi_byte_transceiver_if.master
//                       (send_request/din/cs_at_end/miso in;
//                        mosi/sclk/cs/dout/data_valid/processing/
//                        bit_counter out, all registered)
// Revision    : 1.0 - initial release
// ============================================================================
module spi_byte_transceiver #(
  parameter int HALF_PERIOD = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  spi_byte_transceiver_if.master        bus
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  localparam logic [7:0] c_phase_last = 8'(HALF_PERIOD - 1);

  state_t     r_state;
  logic [7:0] r_phase_cnt;
  logic [7:0] r_tx_shift;     // byte captured on acceptance
  logic [6:0] r_rx_shift;     // the seven most recently sampled bits
  logic       r_cs_at_end;

  logic       r_mosi;
  logic       r_sclk;
  logic       r_cs;
  logic [7:0] r_dout;
  logic       r_data_valid;
  logic       r_processing;
  logic [3:0] r_bit_counter;

  logic [7:0] w_rx_next;
  logic [2:0] w_next_idx;

  // Incoming byte including the bit being sampled this edge.
  assign w_rx_next  = {r_rx_shift, bus.miso};
  // Index of the bit about to start; its tx position is 7 - idx == ~idx.
  assign w_next_idx = r_bit_counter[2:0] + 3'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_phase_cnt   <= 8'd0;
      r_tx_shift    <= 8'd0;
      r_rx_shift    <= 7'd0;
      r_cs_at_end   <= 1'b0;
      r_mosi        <= 1'b0;
      r_sclk        <= 1'b0;
      r_cs          <= 1'b1;
      r_dout        <= 8'd0;
      r_data_valid  <= 1'b0;
      r_processing  <= 1'b0;
      r_bit_counter <= 4'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.send_request) begin
            r_state       <= ST_SHIFT;
            r_tx_shift    <= bus.din;
            r_cs_at_end   <= bus.cs_at_end;
            r_processing  <= 1'b1;
            r_cs          <= 1'b0;
            r_data_valid  <= 1'b0;
            r_bit_counter <= 4'd0;
            r_sclk        <= 1'b0;
            r_mosi        <= bus.din[7];
            r_phase_cnt   <= 8'd0;
          end
        end

        ST_SHIFT: begin
          if (r_phase_cnt != c_phase_last) begin
            r_phase_cnt <= r_phase_cnt + 8'd1;
          end else begin
            r_phase_cnt <= 8'd0;
            if (!r_sclk) begin
              r_sclk <= 1'b1;
            end else begin
              // Last edge of the high phase: sample, drop sclk, advance.
              r_sclk     <= 1'b0;
              r_rx_shift <= w_rx_next[6:0];
              if (r_bit_counter == 4'd7) begin
                r_state       <= ST_IDLE;
                r_processing  <= 1'b0;
                r_mosi        <= 1'b0;
                r_bit_counter <= 4'd8;
                r_dout        <= w_rx_next;
                r_data_valid  <= 1'b1;
                // A clear cs_at_end leaves cs low for a following byte.
                if (r_cs_at_end) begin
                  r_cs <= 1'b1;
                end
              end else begin
                r_bit_counter <= r_bit_counter + 4'd1;
                r_mosi        <= r_tx_shift[~w_next_idx];
              end
            end
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.mosi        = r_mosi;
  assign bus.sclk        = r_sclk;
  assign bus.cs          = r_cs;
  assign bus.dout        = r_dout;
  assign bus.data_valid  = r_data_valid;
  assign bus.processing  = r_processing;
  assign bus.bit_counter = r_bit_counter;

endmodule
`default_nettype wire

// File: tb/tb_spi_byte_transceiver.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_byte_transceiver
// Description : Self-checking bench for spi_byte_transceiver. Two instances
//               (HALF_PERIOD 1 and 3) share clk/reset; one is selected at a
//               time. A slave model returns a chosen byte on miso; expected
//               waveforms come from cycle-index arithmetic per transfer.
// Ports       : none
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_byte_transceiver;

  localparam int c_hp_a = 1;
  localparam int c_hp_b = 3;

  logic clk;
  logic reset;
  logic sel;       // 0 -> u_dut_a, 1 -> u_dut_b

  int n_cmp;
  int n_err;

  spi_byte_transceiver_if if_a ();
  spi_byte_transceiver_if if_b ();

  spi_byte_transceiver #(.HALF_PERIOD(c_hp_a)) u_dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (if_a)
  );

  spi_byte_transceiver #(.HALF_PERIOD(c_hp_b)) u_dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (if_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Outputs of the currently selected instance.
  logic       m_mosi, m_sclk, m_cs, m_dv, m_proc;
  logic [7:0] m_dout;
  logic [3:0] m_bitc;

  always_comb begin
    m_mosi = if_a.mosi;
    m_sclk = if_a.sclk;
    m_cs   = if_a.cs;
    m_dv   = if_a.data_valid;
    m_proc = if_a.processing;
    m_dout = if_a.dout;
    m_bitc = if_a.bit_counter;
    if (sel) begin
      m_mosi = if_b.mosi;
      m_sclk = if_b.sclk;
      m_cs   = if_b.cs;
      m_dv   = if_b.data_valid;
      m_proc = if_b.processing;
      m_dout = if_b.dout;
      m_bitc = if_b.bit_counter;
    end
  end

  // Slave: presents slave_byte MSB first, advancing on each sclk fall.
  logic [7:0] slave_byte;
  int         slave_falls;
  int         slave_base;
  logic       miso_bit;

  initial slave_falls = 0;
  always @(negedge m_sclk) slave_falls <= slave_falls + 1;

  always_comb begin
    logic [2:0] idx;
    idx      = 3'(slave_falls - slave_base);
    miso_bit = slave_byte[~idx];
  end

  assign if_a.miso = miso_bit;
  assign if_b.miso = miso_bit;

  // Reference state per instance.
  logic [7:0] exp_dout [2];
  logic       exp_cs   [2];

  task automatic check_value(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic set_req(input logic r);
    if (sel) if_b.send_request = r;
    else     if_a.send_request = r;
  endtask

  task automatic drive_req(input logic r, input logic [7:0] d, input logic ce);
    if (sel) begin
      if_b.send_request = r; if_b.din = d; if_b.cs_at_end = ce;
    end else begin
      if_a.send_request = r; if_a.din = d; if_a.cs_at_end = ce;
    end
  endtask

  task automatic clear_reqs();
    if_a.send_request = 1'b0;
    if_b.send_request = 1'b0;
  endtask

  task automatic check_reset_state(input string pfx);
    logic keep;
    keep = sel;
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #1;
      check_value($sformatf("%s sclk i%0d", pfx, s), {31'd0, m_sclk}, 32'd0);
      check_value($sformatf("%s mosi i%0d", pfx, s), {31'd0, m_mosi}, 32'd0);
      check_value($sformatf("%s cs i%0d", pfx, s),   {31'd0, m_cs},   32'd1);
      check_value($sformatf("%s proc i%0d", pfx, s), {31'd0, m_proc}, 32'd0);
      check_value($sformatf("%s dv i%0d", pfx, s),   {31'd0, m_dv},   32'd0);
      check_value($sformatf("%s dout i%0d", pfx, s), {24'd0, m_dout}, 32'd0);
      check_value($sformatf("%s bitc i%0d", pfx, s), {28'd0, m_bitc}, 32'd0);
    end
    sel = keep;
    #1;
  endtask

  // One byte on the selected instance. Entered between posedges.
  // hold: leave send_request high after acceptance (back-to-back).
  // poke: transfer cycle at which a one-cycle stray request with din=FF
  //       is issued (-1 for none).
  task automatic run_xfer(input logic [7:0] d, input logic ce,
                          input logic [7:0] sb, input logic hold,
                          input int poke);
    int hp;
    int b;
    logic exp_sclk;
    hp = sel ? c_hp_b : c_hp_a;
    slave_byte = sb;
    slave_base = slave_falls;
    drive_req(1'b1, d, ce);
    @(posedge clk);
    #1;
    if (!hold) set_req(1'b0);
    for (int k = 0; k < 16 * hp; k++) begin
      @(negedge clk);
      b        = k / (2 * hp);
      exp_sclk = ((k % (2 * hp)) >= hp);
      check_value($sformatf("proc k=%0d", k), {31'd0, m_proc}, 32'd1);
      check_value($sformatf("cs k=%0d", k),   {31'd0, m_cs},   32'd0);
      check_value($sformatf("dv k=%0d", k),   {31'd0, m_dv},   32'd0);
      check_value($sformatf("bitc k=%0d", k), {28'd0, m_bitc}, b);
      check_value($sformatf("sclk k=%0d", k), {31'd0, m_sclk}, {31'd0, exp_sclk});
      check_value($sformatf("mosi k=%0d", k), {31'd0, m_mosi}, {31'd0, d[7-b]});
      check_value($sformatf("dout k=%0d", k), {24'd0, m_dout}, {24'd0, exp_dout[sel]});
      if (k == poke) drive_req(1'b1, 8'hFF, ~ce);
      if (poke >= 0 && k == poke + 1) set_req(1'b0);
    end
    @(negedge clk);
    exp_dout[sel] = sb;
    exp_cs[sel]   = ce;
    check_value("done proc", {31'd0, m_proc}, 32'd0);
    check_value("done sclk", {31'd0, m_sclk}, 32'd0);
    check_value("done mosi", {31'd0, m_mosi}, 32'd0);
    check_value("done bitc", {28'd0, m_bitc}, 32'd8);
    check_value("done dout", {24'd0, m_dout}, {24'd0, sb});
    check_value("done dv",   {31'd0, m_dv},   32'd1);
    check_value("done cs",   {31'd0, m_cs},   {31'd0, exp_cs[sel]});
    if (!hold) begin
      @(negedge clk);
      check_value("idle proc", {31'd0, m_proc}, 32'd0);
      check_value("idle dv",   {31'd0, m_dv},   32'd1);
      check_value("idle bitc", {28'd0, m_bitc}, 32'd8);
      check_value("idle cs",   {31'd0, m_cs},   {31'd0, exp_cs[sel]});
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic       r_hold;
    logic       r_sel;
    int         r_poke;
    n_cmp = 0;
    n_err = 0;
    sel   = 1'b0;
    reset = 1'b1;
    slave_byte = 8'h00;
    slave_base = 0;
    if_a.send_request = 1'b0; if_a.din = 8'h00; if_a.cs_at_end = 1'b0;
    if_b.send_request = 1'b0; if_b.din = 8'h00; if_b.cs_at_end = 1'b0;
    for (int s = 0; s < 2; s++) begin
      exp_dout[s] = 8'h00;
      exp_cs[s]   = 1'b1;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check_reset_state("rst");

    // Basic byte on HALF_PERIOD=1.
    run_xfer(8'h03, 1'b1, 8'hA5, 1'b0, -1);
    // cs held low across a back-to-back pair.
    run_xfer(8'h3C, 1'b0, 8'h5E, 1'b1, -1);
    run_xfer(8'hC3, 1'b1, 8'h81, 1'b0, -1);
    // Stray request mid-transfer is ignored.
    run_xfer(8'h00, 1'b1, 8'h3F, 1'b0, 5);
    // HALF_PERIOD=3.
    sel = 1'b1;
    #1;
    run_xfer(8'h80, 1'b1, 8'h12, 1'b0, -1);

    // Reset mid-transfer.
    sel = 1'b0;
    #1;
    slave_byte = 8'hFF;
    slave_base = slave_falls;
    drive_req(1'b1, 8'h5A, 1'b1);
    @(posedge clk);
    #1;
    set_req(1'b0);
    repeat (6) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int s = 0; s < 2; s++) begin
      exp_dout[s] = 8'h00;
      exp_cs[s]   = 1'b1;
    end
    check_reset_state("midrst");

    // Randomized transfers across both instances.
    for (int i = 0; i < 24; i++) begin
      r_sel = 1'($urandom_range(0, 1));
      if (r_sel != sel) begin
        clear_reqs();
        sel = r_sel;
        #1;
      end
      r_hold = 1'($urandom_range(0, 1));
      r_poke = -1;
      if (!r_hold && $urandom_range(0, 1) == 1)
        r_poke = $urandom_range(0, 16 * (sel ? c_hp_b : c_hp_a) - 2);
      run_xfer(8'($urandom), 1'($urandom), 8'($urandom), r_hold, r_poke);
    end
    clear_reqs();
    run_xfer(8'h96, 1'b1, 8'h69, 1'b0, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
